tone_detector: RTL and testbench

TONE_DETECTOR -- requirements
Module: tone_detector

---
 rtl/tone_detector.sv | 185 ++++++++++++++++++
 tb/tb_tone_detector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// Tone period detector: measures the full period of a square-wave tone in
// CLOCK_50 cycles, rejects glitch edges shorter than MIN_PERIOD and drops
// back to silence after TIMEOUT_CYCLES without an accepted edge.
// Optional build macro TONE_DETECTOR_AVG_EN: report the average of the last
// four accepted periods instead of the raw period.
module tone_detector #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned MIN_PERIOD     = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        TONE_IN,
    output logic [31:0] PERIOD,
    output logic        PERIOD_VALID,
    output logic        LOCKED,
    output logic        LED
);

    localparam logic [31:0] LP_MIN_PERIOD = 32'(MIN_PERIOD);
    localparam logic [31:0] LP_TIMEOUT_M1 = 32'(TIMEOUT_CYCLES - 1);

    if (CLK_HZ == 0 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES <= MIN_PERIOD) begin : g_bad_params
        $error("tone_detector: invalid parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StAcquire, StLock} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic        r_rise;
    logic [31:0] r_cnt;
    logic [31:0] r_period;
    logic        r_valid;
    logic        r_locked;
    logic [31:0] w_p;
    logic        w_accept;
    logic        w_timeout;
    logic        w_update;
    logic [31:0] w_period_next;
    logic        w_valid_next;
    logic        w_locked_next;

    // Two-flop synchronizer, previous-level flop and registered rise; the
    // extra rise register sets the three-clock input-to-output latency.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= TONE_IN;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_rise  <= r_sync2 & ~r_sync3;
        end
    end

    // Candidate period is the saturating successor of the cycle counter.
    assign w_p       = (&r_cnt) ? r_cnt : r_cnt + 32'd1;
    assign w_accept  = r_rise && ((r_state == StIdle) || (w_p >= LP_MIN_PERIOD));
    // An accepted edge in the timeout cycle takes priority.
    assign w_timeout = (r_state != StIdle) && !w_accept && (r_cnt == LP_TIMEOUT_M1);
    assign w_update  = w_accept && (r_state != StIdle);

    // Cycle counter: cleared by an accepted edge, otherwise saturating count.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= 32'd0;
        end else if (w_accept) begin
            r_cnt <= 32'd0;
        end else begin
            r_cnt <= w_p;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            unique case (r_state)
                StIdle:    w_state_next = StAcquire;
                StAcquire: w_state_next = StLock;
                StLock:    w_state_next = StLock;
                default:   w_state_next = StIdle;
            endcase
        end else if (w_timeout) begin
            w_state_next = StIdle;
        end
    end

`ifdef TONE_DETECTOR_AVG_EN
    logic [31:0] r_hist [3];
    logic [1:0]  r_hist_cnt;
    logic [33:0] w_sum;
    logic [31:0] w_avg;

    assign w_sum = {2'b00, w_p} + {2'b00, r_hist[0]} + {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
    assign w_avg = 32'(w_sum >> 2);

    // History of the three previous accepted periods; wiped on silence.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hist[0]  <= 32'd0;
            r_hist[1]  <= 32'd0;
            r_hist[2]  <= 32'd0;
            r_hist_cnt <= 2'd0;
        end else if (w_timeout) begin
            r_hist[0]  <= 32'd0;
            r_hist[1]  <= 32'd0;
            r_hist[2]  <= 32'd0;
            r_hist_cnt <= 2'd0;
        end else if (w_update) begin
            r_hist[0] <= w_p;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
            if (r_hist_cnt != 2'd3) begin
                r_hist_cnt <= r_hist_cnt + 2'd1;
            end
        end
    end

    // FSM output logic: publish only once four periods are in the window.
    always_comb begin
        w_period_next = r_period;
        w_valid_next  = 1'b0;
        w_locked_next = r_locked;
        if (w_update && (r_hist_cnt == 2'd3)) begin
            w_period_next = w_avg;
            w_valid_next  = 1'b1;
            w_locked_next = 1'b1;
        end else if (w_timeout) begin
            w_period_next = 32'd0;
            w_locked_next = 1'b0;
        end
    end
`else
    // FSM output logic: publish the raw period on every tracked edge.
    always_comb begin
        w_period_next = r_period;
        w_valid_next  = 1'b0;
        w_locked_next = r_locked;
        if (w_update) begin
            w_period_next = w_p;
            w_valid_next  = 1'b1;
            w_locked_next = 1'b1;
        end else if (w_timeout) begin
            w_period_next = 32'd0;
            w_locked_next = 1'b0;
        end
    end
`endif

    // Output registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_period <= 32'd0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_period <= w_period_next;
            r_valid  <= w_valid_next;
            r_locked <= w_locked_next;
        end
    end

    assign PERIOD       = r_period;
    assign PERIOD_VALID = r_valid;
    assign LOCKED       = r_locked;
    assign LED          = r_locked;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector: drives tone waveforms one clock at a time and
// compares every cycle against a timestamp model of accepted edges.
module tb_tone_detector;

    localparam int unsigned MIN_P = 25;
    localparam int unsigned TO    = 600;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tone  = 1'b0;
    logic [31:0] period;
    logic        valid;
    logic        locked;
    logic        led;

    tone_detector #(
        .CLK_HZ         (50000000),
        .MIN_PERIOD     (MIN_P),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK_50     (clk),
        .RESET_N      (rst_n),
        .TONE_IN      (tone),
        .PERIOD       (period),
        .PERIOD_VALID (valid),
        .LOCKED       (locked),
        .LED          (led)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned n      = 0;     // count of rising clock edges
    int unsigned proc_q[$];      // cycles at which sampled rises take effect
    logic        prev_lvl = 1'b0;
    logic        in_reset = 1'b1;
    int          mode     = 0;   // 0 silent, 1 first edge seen, 2 tracking
    int unsigned last_acc = 0;
    logic [31:0] exp_period = 32'd0;
    logic        exp_valid  = 1'b0;
    logic        exp_locked = 1'b0;
    string       phase = "reset";

    task automatic model_reset();
        proc_q.delete();
        prev_lvl   = 1'b0;
        mode       = 0;
        exp_period = 32'd0;
        exp_valid  = 1'b0;
        exp_locked = 1'b0;
    endtask

    // Expected outputs after clock edge n, from accepted-edge timestamps.
    task automatic model_step();
        bit acc;
        acc       = 1'b0;
        exp_valid = 1'b0;
        if (in_reset) begin
            model_reset();
            return;
        end
        if (proc_q.size() > 0 && proc_q[0] == n) begin
            void'(proc_q.pop_front());
            if (mode == 0) begin
                mode     = 1;
                last_acc = n;
                acc      = 1'b1;
            end else if (n - last_acc >= MIN_P) begin
                exp_period = n - last_acc;
                exp_valid  = 1'b1;
                exp_locked = 1'b1;
                mode       = 2;
                last_acc   = n;
                acc        = 1'b1;
            end
        end
        if (!acc && mode != 0 && (n - last_acc) == TO) begin
            mode       = 0;
            exp_period = 32'd0;
            exp_locked = 1'b0;
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert ({period, valid, locked, led} === {exp_period, exp_valid, exp_locked, exp_locked})
        else begin
            errors++;
            $error("FAIL %s cycle %0d: got period=%0d valid=%b locked=%b led=%b, expected period=%0d valid=%b locked=%b led=%b",
                   phase, n, period, valid, locked, led, exp_period, exp_valid, exp_locked,
                   exp_locked);
        end
    endtask

    // Entered just after a falling clock edge; returns at the next one.
    task automatic step(input logic lvl);
        tone = lvl;
        @(posedge clk);
        n++;
        if (!in_reset && lvl && !prev_lvl) proc_q.push_back(n + 3);
        if (!in_reset) prev_lvl = lvl;
        model_step();
        #1 check_outputs();
        @(negedge clk);
    endtask

    task automatic hold(input logic lvl, input int unsigned cycles);
        repeat (cycles) step(lvl);
    endtask

    task automatic pulse(input int unsigned hi, input int unsigned lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    initial begin
        int unsigned t;
        int unsigned h;

        @(negedge clk);
        hold(1'b0, 3);
        rst_n    = 1'b1;
        in_reset = 1'b0;

        phase = "silent_low";
        hold(1'b0, 100);
        phase = "const_high";
        hold(1'b1, TO + 100);
        hold(1'b0, 50);

        phase = "tone_60";
        repeat (6) pulse(30, 30);

        phase = "glitch";
        pulse(3, 7);
        pulse(2, 50);
        repeat (3) pulse(31, 31);

        phase = "min_reject";
        hold(1'b0, TO + 20);
        pulse(5, 19);
        pulse(1, 5);
        pulse(5, 25);
        phase = "min_accept";
        hold(1'b0, TO + 20);
        pulse(5, 20);
        pulse(5, 20);

        phase = "timeout_tie";
        hold(1'b0, TO - 25);
        pulse(5, 5);
        phase = "timeout_past";
        hold(1'b0, TO + 1 - 10);
        pulse(5, 5);
        pulse(5, 35);

        phase = "reset_mid";
        repeat (3) pulse(40, 40);
        hold(1'b0, 10);
        #2 rst_n = 1'b0;
        in_reset = 1'b1;
        model_reset();
        #1 check_outputs();
        @(posedge clk);
        n++;
        @(negedge clk);
        hold(1'b0, 3);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        repeat (3) pulse(40, 40);

        phase = "random";
        repeat (10) begin
            t = $urandom_range(20, 700);
            h = $urandom_range(1, t - 1);
            repeat ($urandom_range(2, 4)) pulse(h, t - h);
            if ($urandom_range(0, 2) == 0) pulse($urandom_range(1, 4), $urandom_range(1, 15));
        end

        phase = "final_silence";
        hold(1'b0, TO + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
